// File: rtl/mem_wb_stage_if.sv
// rtl/mem_wb_stage_if.sv - MEM/WB stage upstream and writeback handshake bundle
interface mem_wb_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic              in_valid;
    logic              in_ready;
    logic              hit;
    logic              in_reg_write;
    logic              in_mem_to_reg;
    logic [REG_W-1:0]  in_write_reg;
    logic [DATA_W-1:0] in_read_data;
    logic [DATA_W-1:0] in_alu_result;
    logic [1:0]        in_load_size;
    logic              in_load_signed;
    logic              load_stall;

    logic              out_valid;
    logic              out_ready;
    logic              out_reg_write;
    logic [REG_W-1:0]  out_write_reg;
    logic [DATA_W-1:0] out_wb_data;

    modport master (
        output in_valid, hit, in_reg_write, in_mem_to_reg, in_write_reg,
               in_read_data, in_alu_result, in_load_size, in_load_signed,
        input  in_ready, load_stall,
        input  out_valid, out_reg_write, out_write_reg, out_wb_data,
        output out_ready
    );

    modport slave (
        input  in_valid, hit, in_reg_write, in_mem_to_reg, in_write_reg,
               in_read_data, in_alu_result, in_load_size, in_load_signed,
        output in_ready, load_stall,
        output out_valid, out_reg_write, out_write_reg, out_wb_data,
        input  out_ready
    );
endinterface

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB stage: two-entry elastic buffer, load extract, forwarding, miss counter
module mem_wb_stage #(
    parameter int DATA_W       = 32,
    parameter int REG_W        = 5,
    parameter int CNT_W        = 16,
    parameter int ZERO_DISCARD = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    mem_wb_stage_if.slave     bus,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_reg,
    output logic [DATA_W-1:0] fwd_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  miss_cycles
);
    localparam int OFF_W = (DATA_W == 64) ? 3 : 2;

    logic [1:0]        occ;
    logic              regWriteQ [2];
    logic [REG_W-1:0]  writeRegQ [2];
    logic [DATA_W-1:0] wbDataQ   [2];
    logic [CNT_W-1:0]  missCnt;

    logic              loadStall;
    logic              enq;
    logic              deq;
    logic              newRegWrite;
    logic [DATA_W-1:0] newWbData;
    logic [OFF_W-1:0]  byteOff;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] loadData;

    assign loadStall = bus.in_valid & bus.in_mem_to_reg & ~bus.hit;
    assign enq       = bus.in_valid & bus.in_ready & ~loadStall & ~flush;
    assign deq       = bus.out_valid & bus.out_ready & ~flush;

    // Offset is aligned down to the access size before the field is pulled out.
    always_comb begin
        byteOff = bus.in_alu_result[OFF_W-1:0];
        case (bus.in_load_size)
            2'd0:    byteOff = byteOff;
            2'd1:    byteOff = byteOff & ~OFF_W'(1);
            2'd2:    byteOff = byteOff & ~OFF_W'(3);
            default: byteOff = '0;
        endcase
        shifted = bus.in_read_data >> {byteOff, 3'b000};
        case (bus.in_load_size)
            2'd0: loadData = bus.in_load_signed ? DATA_W'($signed(shifted[7:0]))
                                                : DATA_W'(shifted[7:0]);
            2'd1: loadData = bus.in_load_signed ? DATA_W'($signed(shifted[15:0]))
                                                : DATA_W'(shifted[15:0]);
            default: begin
                if (bus.in_load_size == 2'd3 && DATA_W == 64)
                    loadData = shifted;
                else
                    loadData = bus.in_load_signed ? DATA_W'($signed(shifted[31:0]))
                                                  : DATA_W'(shifted[31:0]);
            end
        endcase
    end

    assign newWbData   = bus.in_mem_to_reg ? loadData : bus.in_alu_result;
    assign newRegWrite = bus.in_reg_write &
                         ~((ZERO_DISCARD != 0) && (bus.in_write_reg == '0));

    // Head is always slot 0; a dequeue shifts slot 1 forward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ          <= '0;
            regWriteQ[0] <= 1'b0;
            regWriteQ[1] <= 1'b0;
            writeRegQ[0] <= '0;
            writeRegQ[1] <= '0;
            wbDataQ[0]   <= '0;
            wbDataQ[1]   <= '0;
        end else if (flush) begin
            occ <= '0;
        end else if (deq) begin
            if (enq) begin
                regWriteQ[0] <= newRegWrite;
                writeRegQ[0] <= bus.in_write_reg;
                wbDataQ[0]   <= newWbData;
            end else begin
                regWriteQ[0] <= regWriteQ[1];
                writeRegQ[0] <= writeRegQ[1];
                wbDataQ[0]   <= wbDataQ[1];
                occ          <= occ - 2'd1;
            end
        end else if (enq) begin
            regWriteQ[occ[0]] <= newRegWrite;
            writeRegQ[occ[0]] <= bus.in_write_reg;
            wbDataQ[occ[0]]   <= newWbData;
            occ               <= occ + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            missCnt <= '0;
        else if (loadStall && missCnt != {CNT_W{1'b1}})
            missCnt <= missCnt + CNT_W'(1);
    end

    assign bus.in_ready      = (occ != 2'd2);
    assign bus.load_stall    = loadStall;
    assign bus.out_valid     = (occ != 2'd0);
    assign bus.out_reg_write = regWriteQ[0];
    assign bus.out_write_reg = writeRegQ[0];
    assign bus.out_wb_data   = wbDataQ[0];

    assign fwd_valid   = bus.out_valid & regWriteQ[0];
    assign fwd_reg     = writeRegQ[0];
    assign fwd_data    = wbDataQ[0];
    assign occupancy   = occ;
    assign miss_cycles = missCnt;
endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Parametrised MEM/WB pipeline stage between the data-memory/cache access and register-file writeback. It holds up to two in-flight instructions in an elastic buffer with a valid/ready handshake and load-hit gating. It performs load byte/halfword extraction with sign or zero extension and the MemtoReg writeback select. It also exposes a forwarding port for the head entry and a saturating miss-stall counter.

## Interface
- DATA_W, 32, datapath width; 32 or 64 only
- REG_W, 5, register index width
- CNT_W, 16, miss-stall counter width
- ZERO_DISCARD, 1, when 1 a write to register 0 is emitted with reg_write forced 0
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous discard of all buffered entries
- in_valid  in  1  upstream entry offered
- in_ready  out  1  stage can accept; equals occupancy != 2
- hit  in  1  memory data valid this cycle
- in_reg_write, in_mem_to_reg  in  1 each  control bits
- in_write_reg  in  REG_W  destination register
- in_read_data  in  DATA_W  raw memory word
- in_alu_result  in  DATA_W  ALU result; low bits are the byte address
- in_load_size  in  2  0 byte, 1 half, 2 word, 3 dword (legal only when DATA_W=64)
- in_load_signed  in  1  sign-extend sub-word loads
- load_stall  out  1  in_valid & in_mem_to_reg & !hit
- out_valid  out  1  head entry present
- out_ready  in  1  writeback consumes head
- out_reg_write  out  1  head reg_write after zero discard
- out_write_reg  out  REG_W  head destination
- out_wb_data  out  DATA_W  head writeback value
- fwd_valid  out  1  out_valid & out_reg_write
- fwd_reg  out  REG_W  equals out_write_reg
- fwd_data  out  DATA_W  equals out_wb_data
- occupancy  out  2  entries held, 0..2
- miss_cycles  out  CNT_W  saturating count of load_stall cycles

## Operation
- Entry fields: reg_write, write_reg, wb_data. wb_data is computed at enqueue, not at dequeue.
- Enqueue: enq = in_valid & in_ready & !load_stall & !flush.
- Dequeue: deq = out_valid & out_ready & !flush.
- Ordering is strict FIFO. Head is always entry 0; on deq, entry 1 shifts to entry 0. Simultaneous enq and deq with occupancy 1 replaces the head; occupancy stays 1.
- Occupancy 2 forces in_ready=0, so enq and deq are never simultaneous at full.
- Writeback select: wb_data = in_mem_to_reg ? extract(in_read_data) : in_alu_result.
- extract:
  - Byte offset is off = in_alu_result[log2(DATA_W/8)-1:0], masked to size alignment (half clears bit 0, word clears bits 1:0, dword clears all).
  - Field = in_read_data >> (8*off), truncated to 8/16/32/64 bits, then sign- or zero-extended to DATA_W.
  - Word with DATA_W=32 and dword pass the data through unchanged.
  - Size 3 with DATA_W=32 is treated as word.
- Zero discard: with ZERO_DISCARD=1 and write_reg==0, reg_write is stored as 0.
- flush has priority over enq and deq. The next edge sets occupancy to 0 and leaves stored data unchanged (invisible, since out_valid=0).
- miss_cycles increments each cycle load_stall=1, including during flush. It saturates at all-ones and never wraps.

## Timing
- Reset (rst_n=0, immediate): occupancy 0, out_valid 0, fwd_valid 0, out_reg_write 0, out_write_reg 0, out_wb_data 0, miss_cycles 0, in_ready 1.
- Reset deasserted mid-transfer: all entries are lost; no partial output appears.
- Latency: enq at edge N gives out_valid=1 after edge N when the buffer was empty. Throughput is 1 entry/cycle with out_ready held 1.
- in_ready and out_valid derive from registered occupancy only, with no combinational path from out_ready or hit.
- load_stall is combinational from inputs. While it is high, upstream must hold all in_* stable.
- out_* remain stable while out_valid & !out_ready.

## Test plan
- Reset then ALU op: write_reg=5, mem_to_reg=0, alu=0x1234, out_ready=1 -> next cycle out_valid=1, out_wb_data=0x1234, fwd_valid=1, fwd_reg=5.
- Signed byte load: DATA_W=32, read_data=0x80FF7F01, alu low bits=2, size=0, signed=1 -> wb_data=0xFFFFFFFF. Same with signed=0 -> 0x000000FF. Half at offset 3 (masked to 2), signed -> 0xFFFF80FF.
- Miss: mem_to_reg=1, hit=0 for 3 cycles, then 1 -> load_stall high 3 cycles, miss_cycles=3, single entry enqueued on the hit cycle.
- Backpressure: out_ready=0, offer 3 entries -> occupancy 2, in_ready=0, third held. Raise out_ready -> outputs in order A, B, C with no loss or duplication.
- Flush with occupancy 2 and in_valid=1 -> next cycle occupancy 0, out_valid 0, offered entry not taken.
- Write to register 0 with ZERO_DISCARD=1 -> out_valid=1, out_reg_write=0, fwd_valid=0. Separately, force load_stall for 2^CNT_W+5 cycles with CNT_W=4 -> miss_cycles holds at 15.
